// File: rtl/i2s_pkg.sv
// Shared constants for the I2S receive path: default word size, channel
// encodings and synchronizer depth.
package i2s_pkg;

  localparam int unsigned WORD_SIZE_DEFAULT = 24;
  localparam int unsigned SYNC_STAGES       = 2;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchronizer for one edge-detected lane plus equal-depth
// sync-only taps, so every lane leaves with the same latency.
module i2s_sync_edge #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAPS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            edge_in,
  input  logic [TAPS-1:0] tap_in,
  output logic [TAPS-1:0] tap_q,
  output logic            rise
);

  logic [TAPS:0] sync_q [STAGES];
  logic          edge_prev;

  // The edge flop and the tap output register share one stage, so tap_q is
  // the value that accompanied the edge lane when rise is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      tap_q     <= '0;
      edge_prev <= 1'b0;
      rise      <= 1'b0;
    end else begin
      sync_q[0] <= {tap_in, edge_in};
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      tap_q     <= sync_q[STAGES-1][TAPS:1];
      edge_prev <= sync_q[STAGES-1][0];
      rise      <= sync_q[STAGES-1][0] & ~edge_prev;
    end
  end

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S slave receiver: recovers left/right sample pairs from an
// asynchronous sclk/lrclk/sd stream in the clk domain.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 lrclk,
  input  logic                 sd,
  output logic [WORD_SIZE-1:0] left_data,
  output logic [WORD_SIZE-1:0] right_data,
  output logic                 frame_valid,
  output logic                 word_err
);

  localparam int unsigned CW = $clog2(WORD_SIZE + 1);
  localparam logic [CW-1:0] WS_C = CW'(WORD_SIZE);

  logic                 rise;
  logic                 ws;
  logic                 sdb;

  logic [WORD_SIZE-1:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic                 ws_prev;
  logic                 locked;
  logic [WORD_SIZE-1:0] left_hold;
  logic                 have_left;

  logic [WORD_SIZE-1:0] sh_shift;
  logic [CW-1:0]        cnt_next;
  logic [CW-1:0]        pad_amt;
  logic [WORD_SIZE-1:0] word;
  logic                 short_word;

  i2s_sync_edge #(
    .STAGES (SYNC_STAGES),
    .TAPS   (2)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .edge_in (sclk),
    .tap_in  ({lrclk, sd}),
    .tap_q   ({ws, sdb}),
    .rise    (rise)
  );

  // Next shift-register contents with the current bit taken in; shared by
  // data bits and the word-closing bit. Short words are left-aligned.
  always_comb begin
    sh_shift = shreg;
    cnt_next = bit_cnt;
    if (bit_cnt < WS_C) begin
      sh_shift = {shreg[WORD_SIZE-2:0], sdb};
      cnt_next = bit_cnt + 1'b1;
    end
    pad_amt    = WS_C - cnt_next;
    word       = sh_shift << pad_amt;
    short_word = (cnt_next < WS_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      ws_prev     <= CH_LEFT;
      locked      <= 1'b0;
      left_hold   <= '0;
      have_left   <= 1'b0;
      left_data   <= '0;
      right_data  <= '0;
      frame_valid <= 1'b0;
      word_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      word_err    <= 1'b0;
      if (rise) begin
        if (ws == ws_prev) begin
          shreg   <= sh_shift;
          bit_cnt <= cnt_next;
        end else begin
          if (!locked) begin
            locked    <= 1'b1;
            have_left <= 1'b0;
          end else if (ws_prev == CH_LEFT) begin
            left_hold <= word;
            have_left <= 1'b1;
            word_err  <= short_word;
          end else if (have_left) begin
            // A right word is only published together with its left partner.
            right_data  <= word;
            left_data   <= left_hold;
            frame_valid <= 1'b1;
            have_left   <= 1'b0;
            word_err    <= short_word;
          end
          shreg   <= '0;
          bit_cnt <= '0;
          ws_prev <= ws;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Randomized I2S stream bench with a word-level reference model.
module tb_i2s_receiver;

  localparam int WS = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          sclk;
  logic          lrclk;
  logic          sd;
  logic [WS-1:0] left_data;
  logic [WS-1:0] right_data;
  logic          frame_valid;
  logic          word_err;

  i2s_receiver #(.WORD_SIZE(WS)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .lrclk       (lrclk),
    .sd          (sd),
    .left_data   (left_data),
    .right_data  (right_data),
    .frame_valid (frame_valid),
    .word_err    (word_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: bits of the word in progress, kept as a queue.
  bit            m_bits[$];
  bit            m_ws_prev;
  bit            m_locked;
  bit            m_have;
  logic [WS-1:0] m_left;
  logic [2*WS-1:0] exp_q[$];
  int            exp_err = 0;
  int            exp_fv  = 0;
  int            dut_err = 0;
  int            dut_fv  = 0;
  logic [WS-1:0] last_left = '0;
  bit            sd_delay = 1'b0;

  task automatic model_clear();
    m_bits.delete();
    m_ws_prev = 1'b0;
    m_locked  = 1'b0;
    m_have    = 1'b0;
  endtask

  task automatic model_rise(input bit ws, input bit b);
    logic [WS-1:0] w;
    int n;
    if (m_bits.size() < WS) m_bits.push_back(b);
    if (ws != m_ws_prev) begin
      n = m_bits.size();
      w = '0;
      for (int i = 0; i < n; i++) w[WS-1-i] = m_bits[i];
      if (!m_locked) begin
        m_locked = 1'b1;
        m_have   = 1'b0;
      end else if (m_ws_prev == 1'b0) begin
        m_left = w;
        m_have = 1'b1;
        if (n < WS) exp_err++;
      end else if (m_have) begin
        exp_q.push_back({m_left, w});
        exp_fv++;
        m_have = 1'b0;
        if (n < WS) exp_err++;
      end
      m_bits.delete();
      m_ws_prev = ws;
    end
  endtask

  always @(negedge clk) begin
    logic [2*WS-1:0] pair;
    if (!reset) begin
      if (frame_valid) begin
        dut_fv++;
        last_left = left_data;
        check_eq("fv_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          pair = exp_q.pop_front();
          check_eq("left_data", 32'(left_data), 32'(pair[2*WS-1:WS]));
          check_eq("right_data", 32'(right_data), 32'(pair[WS-1:0]));
        end
      end
      if (word_err) dut_err++;
    end
  end

  // One sclk period: lrclk/sd change on the falling edge, sd lags one slot.
  task automatic slot(input bit ws, input bit nb);
    @(negedge clk);
    sclk     = 1'b0;
    lrclk    = ws;
    sd       = sd_delay;
    sd_delay = nb;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    model_rise(ws, sd);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input bit ws, input logic [31:0] w, input int n,
                           input int first, input int last);
    for (int i = first; i < last; i++) slot(ws, w[n-1-i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int n);
    send_bits(1'b0, l, n, 0, n);
    send_bits(1'b1, r, n, 0, n);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check_eq({tag, "_left"}, 32'(left_data), 32'd0);
    check_eq({tag, "_right"}, 32'(right_data), 32'd0);
    check_eq({tag, "_fv"}, 32'(frame_valid), 32'd0);
    check_eq({tag, "_err"}, 32'(word_err), 32'd0);
    reset = 1'b0;
  endtask

  task automatic checkpoint(input string tag);
    repeat (6) @(negedge clk);
    check_eq({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_fv_cnt"}, 32'(dut_fv), 32'(exp_fv));
    check_eq({tag, "_err_cnt"}, 32'(dut_err), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] l;
    logic [31:0] r;
    int n;
    reset = 1'b1;
    sclk  = 1'b0;
    lrclk = 1'b0;
    sd    = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("por_left", 32'(left_data), 32'd0);
    check_eq("por_right", 32'(right_data), 32'd0);
    check_eq("por_fv", 32'(frame_valid), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) send_frame(32'hffffff, 32'h000000, 24);
    checkpoint("const");
    check_eq("const_left", 32'(last_left), 32'h00ffffff);

    for (int i = 0; i < 3; i++) send_frame(32'h010101, 32'h101010, 24);
    checkpoint("change");
    check_eq("change_left", 32'(last_left), 32'h00010101);

    for (int i = 0; i < 6; i++) send_frame($urandom(), $urandom(), 24);
    checkpoint("rand24");

    l = $urandom();
    send_bits(1'b0, l, 24, 0, 12);
    do_reset("midrst");
    send_bits(1'b0, l, 24, 12, 24);
    send_bits(1'b1, $urandom(), 24, 0, 24);
    for (int i = 0; i < 3; i++) send_frame($urandom(), $urandom(), 24);
    checkpoint("midrst");

    for (int i = 0; i < 3; i++) send_frame(32'h0000abcd, $urandom(), 16);
    checkpoint("short16");
    check_eq("short16_left", 32'(last_left), 32'h00abcd00);

    for (int i = 0; i < 3; i++) send_frame(32'h12345678, $urandom(), 32);
    checkpoint("long32");
    check_eq("long32_left", 32'(last_left), 32'h00123456);

    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(32, 8);
      send_frame($urandom(), $urandom(), n);
    end
    checkpoint("randlen");

    for (int i = 0; i < 60; i++) slot(1'b0, 1'($urandom()));
    checkpoint("idle");

    r = $urandom();
    send_bits(1'b1, r, 24, 0, 10);
    do_reset("hirst");
    send_bits(1'b1, r, 24, 10, 24);
    for (int i = 0; i < 4; i++) send_frame($urandom(), $urandom(), 24);
    checkpoint("hirst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
